// File: rtl/llc_issue_sched_pkg.sv
//------------------------------------------------------------------------------
// llc_issue_sched_pkg: shared source codes and scoreboard/issue packet types.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package llc_issue_sched_pkg;

  localparam int LLC_SET_BITS = 9;
  localparam int LLC_INFLIGHT = 4;

  localparam logic [1:0] SRC_RST = 2'd0;
  localparam logic [1:0] SRC_RSP = 2'd1;
  localparam logic [1:0] SRC_REQ = 2'd2;
  localparam logic [1:0] SRC_DMA = 2'd3;

  typedef struct packed {
    logic                    valid;
    logic [LLC_SET_BITS-1:0] set;
  } sb_entry_t;

  typedef struct packed {
    logic [1:0]                      src;
    logic [LLC_SET_BITS-1:0]         set;
    logic [$clog2(LLC_INFLIGHT)-1:0] idx;
  } issue_pkt_t;

endpackage

`default_nettype wire

// File: rtl/llc_set_scoreboard.sv
//------------------------------------------------------------------------------
// llc_set_scoreboard: in-flight set table with lowest-free allocator and retire.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module llc_set_scoreboard
  import llc_issue_sched_pkg::*;
#(
  parameter int SET_BITS = LLC_SET_BITS,
  parameter int INFLIGHT = LLC_INFLIGHT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc,
  input  logic [SET_BITS-1:0]         alloc_set,
  output logic [$clog2(INFLIGHT)-1:0] free_idx,
  input  logic                        retire_valid,
  input  logic [$clog2(INFLIGHT)-1:0] retire_idx,
  input  logic [SET_BITS-1:0]         lookup_a,
  input  logic [SET_BITS-1:0]         lookup_b,
  output logic                        hit_a,
  output logic                        hit_b,
  output logic                        full,
  output logic                        empty
);

  localparam int IDX_W = $clog2(INFLIGHT);

  sb_entry_t           r_entries [INFLIGHT];
  logic [INFLIGHT-1:0] w_valid;
  logic [INFLIGHT-1:0] w_hit_a;
  logic [INFLIGHT-1:0] w_hit_b;

  // Allocation is applied after retire so an allocation into a slot that is
  // (redundantly) retired in the same cycle keeps the new entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INFLIGHT; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (retire_valid) begin
        r_entries[retire_idx].valid <= 1'b0;
      end
      if (alloc) begin
        r_entries[free_idx] <= '{valid: 1'b1, set: alloc_set};
      end
    end
  end

  always_comb begin
    w_valid  = '0;
    w_hit_a  = '0;
    w_hit_b  = '0;
    free_idx = '0;
    for (int i = INFLIGHT - 1; i >= 0; i--) begin
      w_valid[i] = r_entries[i].valid;
      w_hit_a[i] = r_entries[i].valid && (r_entries[i].set == lookup_a);
      w_hit_b[i] = r_entries[i].valid && (r_entries[i].set == lookup_b);
      if (!r_entries[i].valid) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign hit_a = |w_hit_a;
  assign hit_b = |w_hit_b;
  assign full  = &w_valid;
  assign empty = ~|w_valid;

endmodule

`default_nettype wire

// File: rtl/llc_issue_sched.sv
//------------------------------------------------------------------------------
// llc_issue_sched: LLC front-end arbiter/issue register; LLC_STARVE_GUARD_EN
// enables the rsp-over-req/dma starvation override.          Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module llc_issue_sched
  import llc_issue_sched_pkg::*;
#(
  parameter int SET_BITS = LLC_SET_BITS,
  parameter int INFLIGHT = LLC_INFLIGHT
`ifdef LLC_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rst_tb_valid,
  output logic                        rst_tb_ready,
  input  logic                        rsp_valid,
  output logic                        rsp_ready,
  input  logic [SET_BITS-1:0]         rsp_set,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SET_BITS-1:0]         req_set,
  input  logic                        dma_valid,
  output logic                        dma_ready,
  input  logic [SET_BITS-1:0]         dma_set,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [1:0]                  issue_src,
  output logic [SET_BITS-1:0]         issue_set,
  output logic [$clog2(INFLIGHT)-1:0] issue_idx,
  input  logic                        retire_valid,
  input  logic [$clog2(INFLIGHT)-1:0] retire_idx,
  output logic                        sb_empty,
  output logic                        drain_busy
);

  localparam int IDX_W = $clog2(INFLIGHT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  issue_pkt_t          r_issue;
  logic                r_issue_valid;
  logic                r_rr_dma;

  logic                w_full;
  logic                w_empty;
  logic                w_req_hit;
  logic                w_dma_hit;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_issue_free;
  logic                w_rsp_elig;
  logic                w_req_elig;
  logic                w_dma_elig;
  logic                w_rd_any;
  logic                w_pick_dma;
  logic                w_override;
  logic                w_acc_rsp;
  logic                w_acc_req;
  logic                w_acc_dma;
  logic                w_acc_rst;
  logic                w_rst_rdy;
  logic                w_alloc;
  logic [1:0]          w_alloc_src;
  logic [SET_BITS-1:0] w_alloc_set;

  llc_set_scoreboard #(
    .SET_BITS (SET_BITS),
    .INFLIGHT (INFLIGHT)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .alloc        (w_alloc),
    .alloc_set    (w_alloc_set),
    .free_idx     (w_free_idx),
    .retire_valid (retire_valid),
    .retire_idx   (retire_idx),
    .lookup_a     (req_set),
    .lookup_b     (dma_set),
    .hit_a        (w_req_hit),
    .hit_b        (w_dma_hit),
    .full         (w_full),
    .empty        (w_empty)
  );

  // Readies are held low while reset is asserted.
  assign w_issue_free = !rst && (!r_issue_valid || issue_ready);
  assign w_rsp_elig   = rsp_valid && !w_full;
  assign w_req_elig   = req_valid && !w_full && !w_req_hit;
  assign w_dma_elig   = dma_valid && !w_full && !w_dma_hit;
  assign w_rd_any     = w_req_elig || w_dma_elig;
  assign w_pick_dma   = w_dma_elig && (r_rr_dma || !w_req_elig);

`ifdef LLC_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_override = (r_starve_cnt == CNT_W'(STARVE_LIMIT)) && w_rd_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_acc_req || w_acc_dma) begin
      r_starve_cnt <= '0;
    end else if (w_acc_rsp && w_rd_any && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end
`else
  assign w_override = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_rsp   = 1'b0;
    w_acc_req   = 1'b0;
    w_acc_dma   = 1'b0;
    w_rst_rdy   = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A pending flush blocks all other accepts from the cycle it appears.
        if (rst_tb_valid) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_issue_free) begin
          if (w_rsp_elig && !w_override) begin
            w_acc_rsp = 1'b1;
          end else if (w_rd_any) begin
            w_acc_dma = w_pick_dma;
            w_acc_req = !w_pick_dma;
          end
        end
      end
      ST_DRAIN: begin
        w_rst_rdy = w_empty && w_issue_free;
        if (w_rst_rdy && rst_tb_valid) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_acc_rst = w_rst_rdy && rst_tb_valid;
  assign w_alloc   = w_acc_rsp || w_acc_req || w_acc_dma;

  always_comb begin
    w_alloc_src = SRC_DMA;
    w_alloc_set = dma_set;
    if (w_acc_rsp) begin
      w_alloc_src = SRC_RSP;
      w_alloc_set = rsp_set;
    end else if (w_acc_req) begin
      w_alloc_src = SRC_REQ;
      w_alloc_set = req_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_issue_valid <= 1'b0;
      r_issue       <= '0;
      r_rr_dma      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_alloc) begin
        r_issue_valid <= 1'b1;
        r_issue       <= '{src: w_alloc_src, set: w_alloc_set, idx: w_free_idx};
      end else if (w_acc_rst) begin
        r_issue_valid <= 1'b1;
        r_issue       <= '{src: SRC_RST, set: '0, idx: '0};
      end else if (issue_ready) begin
        r_issue_valid <= 1'b0;
      end
      // Pointer moves to whichever of req/dma lost this grant.
      if (w_acc_req) begin
        r_rr_dma <= 1'b1;
      end else if (w_acc_dma) begin
        r_rr_dma <= 1'b0;
      end
    end
  end

  assign rst_tb_ready = w_rst_rdy;
  assign rsp_ready    = w_acc_rsp;
  assign req_ready    = w_acc_req;
  assign dma_ready    = w_acc_dma;
  assign issue_valid  = r_issue_valid;
  assign issue_src    = r_issue.src;
  assign issue_set    = r_issue.set;
  assign issue_idx    = r_issue.idx;
  assign sb_empty     = w_empty;
  assign drain_busy   = (r_state == ST_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_llc_issue_sched.sv
//------------------------------------------------------------------------------
// tb_llc_issue_sched: vector table, directed corner sequences and a random run
// against a cycle-level reference model of the issue scheduler.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_llc_issue_sched;

  localparam int STARVE_LIMIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_tb_valid, rst_tb_ready;
  logic       rsp_valid, rsp_ready;
  logic [8:0] rsp_set;
  logic       req_valid, req_ready;
  logic [8:0] req_set;
  logic       dma_valid, dma_ready;
  logic [8:0] dma_set;
  logic       issue_valid, issue_ready;
  logic [1:0] issue_src;
  logic [8:0] issue_set;
  logic [1:0] issue_idx;
  logic       retire_valid;
  logic [1:0] retire_idx;
  logic       sb_empty, drain_busy;

  always #5 clk = ~clk;

  llc_issue_sched dut (
    .clk          (clk),
    .rst          (rst),
    .rst_tb_valid (rst_tb_valid),
    .rst_tb_ready (rst_tb_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_set      (rsp_set),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_set      (req_set),
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .dma_set      (dma_set),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_src    (issue_src),
    .issue_set    (issue_set),
    .issue_idx    (issue_idx),
    .retire_valid (retire_valid),
    .retire_idx   (retire_idx),
    .sb_empty     (sb_empty),
    .drain_busy   (drain_busy)
  );

  logic [19:0] dut_vec;
  assign dut_vec = {rst_tb_ready, rsp_ready, req_ready, dma_ready, issue_valid,
                    issue_src, issue_set, issue_idx, sb_empty, drain_busy};

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  bit         m_v [4];
  logic [8:0] m_s [4];
  bit         m_drain, m_rr, m_iv;
  logic [1:0] m_src, m_idx;
  logic [8:0] m_set;
  int         m_cnt;
  int         e_g, e_free;     // e_g: accepted source (-1 none, 0 rst_tb, 1 rsp, 2 req, 3 dma)
  bit         e_wait, e_empty;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_s[i] = '0; end
    m_drain = 0; m_rr = 0; m_iv = 0; m_src = '0; m_idx = '0; m_set = '0; m_cnt = 0;
  endfunction

  function automatic bit set_busy(logic [8:0] s);
    for (int i = 0; i < 4; i++) if (m_v[i] && m_s[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [19:0] model_eval();
    bit free_iss, reqe, dmae, ovr, rst_ok;
    int n;
    n = 0; e_free = -1;
    for (int i = 3; i >= 0; i--) begin
      if (m_v[i]) n++;
      else e_free = i;
    end
    e_empty = (n == 0);
    free_iss = !m_iv || issue_ready;
    e_g = -1; e_wait = 0; rst_ok = 0;
    if (!m_drain) begin
      if (!rst_tb_valid && free_iss && e_free >= 0) begin
        reqe = req_valid && !set_busy(req_set);
        dmae = dma_valid && !set_busy(dma_set);
        e_wait = reqe || dmae;
        ovr = 0;
`ifdef LLC_STARVE_GUARD_EN
        ovr = (m_cnt >= STARVE_LIMIT) && e_wait;
`endif
        if (rsp_valid && !ovr) e_g = 1;
        else if (reqe && dmae) e_g = m_rr ? 3 : 2;
        else if (reqe) e_g = 2;
        else if (dmae) e_g = 3;
      end
    end else if (e_empty && free_iss) begin
      rst_ok = 1;
      if (rst_tb_valid) e_g = 0;
    end
    return {rst_ok, e_g == 1, e_g == 2, e_g == 3, m_iv, m_src, m_set, m_idx, e_empty, m_drain};
  endfunction

  function automatic void model_commit();
    logic [8:0] ns;
    ns = (e_g == 1) ? rsp_set : (e_g == 2) ? req_set : dma_set;
    if (retire_valid) m_v[retire_idx] = 0;
    if (e_g >= 1) begin m_v[e_free] = 1; m_s[e_free] = ns; end
    if (e_g >= 0) begin
      m_iv = 1; m_src = 2'(e_g);
      m_set = (e_g == 0) ? 9'd0 : ns;
      m_idx = (e_g == 0) ? 2'd0 : 2'(e_free);
    end else if (issue_ready) m_iv = 0;
    if (!m_drain && rst_tb_valid) m_drain = 1;
    else if (e_g == 0) m_drain = 0;
    if (e_g == 2) m_rr = 1;
    else if (e_g == 3) m_rr = 0;
    if (e_g == 2 || e_g == 3) m_cnt = 0;
    else if (e_g == 1 && e_wait && m_cnt < STARVE_LIMIT) m_cnt++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rst_tb_valid = 0; rsp_valid = 0; req_valid = 0; dma_valid = 0;
    rsp_set = '0; req_set = '0; dma_set = '0;
    issue_ready = 1; retire_valid = 0; retire_idx = '0;
  endtask

  task automatic settle(string tag);
    #2;
    check(tag, dut_vec, model_eval());
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset(string tag);
    rst = 1; idle();
    #2;
    check(tag, dut_vec, 20'h00002);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rspv; logic [8:0] rsps; logic reqv; logic [8:0] reqs; logic dmav; logic [8:0] dmas;
    logic ir; logic retv; logic [1:0] reti;
    logic [3:0] rdy; logic iv; logic [1:0] src; logic [8:0] set; logic [1:0] idx;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic rspv, logic [8:0] rsps, logic reqv, logic [8:0] reqs,
                              logic dmav, logic [8:0] dmas, logic ir, logic retv, logic [1:0] reti,
                              logic [3:0] rdy, logic iv, logic [1:0] src, logic [8:0] set,
                              logic [1:0] idx);
    vec_t v;
    v.rspv = rspv; v.rsps = rsps; v.reqv = reqv; v.reqs = reqs; v.dmav = dmav; v.dmas = dmas;
    v.ir = ir; v.retv = retv; v.reti = reti;
    v.rdy = rdy; v.iv = iv; v.src = src; v.set = set; v.idx = idx;
    return v;
  endfunction

  int n_rsp, prev_idx;
  bit got_req, have_prev;

  initial begin
    // rdy = {rst_tb, rsp, req, dma}; issue fields are those visible in the same cycle
    tbl[0]  = mk(0, 0,     1, 9'h12, 0, 0,     1, 0, 0, 4'b0010, 0, 0, 9'h000, 0);
    tbl[1]  = mk(0, 0,     0, 0,     1, 9'h12, 1, 0, 0, 4'b0000, 1, 2, 9'h012, 0);
    tbl[2]  = mk(0, 0,     0, 0,     1, 9'h12, 1, 1, 0, 4'b0000, 0, 2, 9'h012, 0);
    tbl[3]  = mk(0, 0,     0, 0,     1, 9'h12, 1, 0, 0, 4'b0001, 0, 2, 9'h012, 0);
    tbl[4]  = mk(0, 0,     1, 9'h20, 1, 9'h21, 1, 1, 0, 4'b0010, 1, 3, 9'h012, 0);
    tbl[5]  = mk(0, 0,     1, 9'h22, 1, 9'h21, 1, 1, 1, 4'b0001, 1, 2, 9'h020, 1);
    tbl[6]  = mk(0, 0,     1, 9'h22, 1, 9'h23, 1, 1, 0, 4'b0010, 1, 3, 9'h021, 0);
    tbl[7]  = mk(0, 0,     1, 9'h24, 1, 9'h23, 1, 1, 1, 4'b0001, 1, 2, 9'h022, 1);
    tbl[8]  = mk(0, 0,     0, 0,     0, 0,     1, 1, 0, 4'b0000, 1, 3, 9'h023, 0);
    tbl[9]  = mk(1, 9'h40, 0, 0,     0, 0,     0, 0, 0, 4'b0100, 0, 3, 9'h023, 0);
    tbl[10] = mk(1, 9'h41, 0, 0,     0, 0,     0, 0, 0, 4'b0000, 1, 1, 9'h040, 0);
    tbl[11] = mk(1, 9'h41, 0, 0,     0, 0,     0, 0, 0, 4'b0000, 1, 1, 9'h040, 0);
    tbl[12] = mk(1, 9'h41, 0, 0,     0, 0,     1, 1, 0, 4'b0100, 1, 1, 9'h040, 0);
    tbl[13] = mk(0, 0,     0, 0,     0, 0,     1, 1, 1, 4'b0000, 1, 1, 9'h041, 1);
    tbl[14] = mk(0, 0,     0, 0,     0, 0,     1, 0, 0, 4'b0000, 0, 1, 9'h041, 1);

    rst = 1; idle(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", dut_vec, 20'h00002);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      idle();
      rsp_valid = tbl[i].rspv; rsp_set = tbl[i].rsps;
      req_valid = tbl[i].reqv; req_set = tbl[i].reqs;
      dma_valid = tbl[i].dmav; dma_set = tbl[i].dmas;
      issue_ready = tbl[i].ir; retire_valid = tbl[i].retv; retire_idx = tbl[i].reti;
      settle($sformatf("table_model_%0d", i));
      check($sformatf("table_vec_%0d", i),
            {rst_tb_ready, rsp_ready, req_ready, dma_ready, issue_valid, issue_src, issue_set, issue_idx},
            {tbl[i].rdy, tbl[i].iv, tbl[i].src, tbl[i].set, tbl[i].idx});
      tick();
    end

    // Full scoreboard, then retire slot 2 and reuse it
    do_reset("full_reset");
    for (int i = 0; i < 4; i++) begin
      idle(); req_valid = 1; req_set = 9'h80 + 9'(i);
      settle("full_fill");
      tick();
    end
    idle(); req_valid = 1; req_set = 9'h90; rsp_valid = 1; rsp_set = 9'h91;
    settle("full_block");
    check("full_req_ready", req_ready, 0);
    check("full_rsp_ready", rsp_ready, 0);
    tick();
    retire_valid = 1; retire_idx = 2;
    settle("full_retire");
    check("full_retire_same_cycle", req_ready, 0);
    tick();
    idle(); req_valid = 1; req_set = 9'h90;
    settle("full_reuse");
    check("full_reuse_ready", req_ready, 1);
    tick();
    idle();
    settle("full_reuse_issue");
    check("full_reuse_idx", issue_idx, 2);
    tick();

    // Response bypasses a set hazard
    do_reset("bypass_reset");
    idle(); req_valid = 1; req_set = 9'h40;
    settle("bypass_req");
    tick();
    idle(); rsp_valid = 1; rsp_set = 9'h40;
    settle("bypass_rsp");
    check("bypass_rsp_ready", rsp_ready, 1);
    tick();
    idle();
    settle("bypass_issue");
    check("bypass_src", {issue_valid, issue_src, issue_set}, {1'b1, 2'd1, 9'h40});
    tick();

    // Drain with three operations in flight
    do_reset("drain_reset");
    for (int i = 0; i < 3; i++) begin
      idle(); req_valid = 1; req_set = 9'h50 + 9'(i);
      settle("drain_fill");
      tick();
    end
    idle(); rst_tb_valid = 1; req_valid = 1; req_set = 9'h60;
    settle("drain_enter");
    check("drain_enter_readies", {rst_tb_ready, req_ready}, 2'b00);
    tick();
    settle("drain_wait");
    check("drain_busy", {drain_busy, req_ready, rst_tb_ready}, 3'b100);
    tick();
    for (int i = 0; i < 3; i++) begin
      retire_valid = 1; retire_idx = 2'(i);
      settle("drain_retire");
      check("drain_retire_rst_ready", rst_tb_ready, 0);
      tick();
    end
    retire_valid = 0;
    settle("drain_done");
    check("drain_rst_ready", {sb_empty, rst_tb_ready}, 2'b11);
    tick();
    rst_tb_valid = 0;
    settle("drain_issue");
    check("drain_issue_pkt", {issue_valid, issue_src, issue_set, drain_busy, req_ready},
          {1'b1, 2'd0, 9'h000, 1'b0, 1'b1});
    tick();

    // Starvation: rsp always valid, req waiting on a free set
    do_reset("starve_reset");
    n_rsp = 0; got_req = 0; have_prev = 0; prev_idx = 0;
    for (int c = 0; c < 20; c++) begin
      idle();
      rsp_valid = 1; rsp_set = 9'h10 + 9'(c);
      req_valid = 1; req_set = 9'h100;
      retire_valid = have_prev; retire_idx = 2'(prev_idx);
      settle("starve_cycle");
      have_prev = (e_g == 1);
      prev_idx = e_free;
      if (rsp_ready) n_rsp++;
      if (req_ready) got_req = 1;
      tick();
      if (got_req) break;
    end
`ifdef LLC_STARVE_GUARD_EN
    check("starve_rsp_grants", {31'(n_rsp), got_req}, {31'(STARVE_LIMIT), 1'b1});
`else
    check("starve_rsp_grants", {31'(n_rsp), got_req}, {31'd20, 1'b0});
`endif

    // Random traffic against the model, with occasional async resets
    do_reset("rand_reset");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        rsp_valid = 1; req_valid = 1; dma_valid = 1;
        rst = 1;
        #2;
        check("rand_async_reset", dut_vec, 20'h00002);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
      end
      rst_tb_valid = m_drain ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
      rsp_valid = ($urandom_range(0, 3) == 0);
      req_valid = ($urandom_range(0, 1) == 0);
      dma_valid = ($urandom_range(0, 1) == 0);
      rsp_set = 9'($urandom_range(0, 7) + 256 * $urandom_range(0, 1));
      req_set = 9'($urandom_range(0, 7) + 256 * $urandom_range(0, 1));
      dma_set = 9'($urandom_range(0, 7) + 256 * $urandom_range(0, 1));
      issue_ready = ($urandom_range(0, 3) != 0);
      retire_valid = ($urandom_range(0, 1) == 0);
      retire_idx = 2'($urandom_range(0, 3));
      settle("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
